// File: rtl/writeback_stage.sv
// Write-back stage: consumer end of the MEM/WB latch.
// Selects write-back destination and data, owns the 32x32 architectural
// register file, serves two decode read ports with same-cycle write bypass,
// drives a zero-latency forwarding tap, latches halt and counts retirements.
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   valid_WB                 latch holds a real instruction (0 = bubble)
//   RegWr_WB, memtoReg_WB    write enable / load-data select
//   RegDst_WB                00 rt, 01 rd, 10 LINK_REG, 11 no write
//   Output_Port_WB           ALU result
//   dmemload_WB              load data
//   imemaddr_WB              instruction PC (link value = PC + 4)
//   instr_WB                 raw instruction (opcode, rt, rd fields)
//   rsel1/rsel2 -> rdat1/2   combinational read ports with bypass
//   fwd_valid/sel/data       register write occurring this cycle
//   halt                     sticky halt
//   retired                  retired-instruction counter
module writeback_stage #(
    parameter logic [5:0]  HALT_OP  = 6'b111111,
    parameter logic [4:0]  LINK_REG = 5'd31,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             valid_WB,
    input  logic             RegWr_WB,
    input  logic             memtoReg_WB,
    input  logic [1:0]       RegDst_WB,
    input  logic [31:0]      Output_Port_WB,
    input  logic [31:0]      dmemload_WB,
    input  logic [31:0]      imemaddr_WB,
    input  logic [31:0]      instr_WB,
    input  logic [4:0]       rsel1,
    input  logic [4:0]       rsel2,
    output logic [31:0]      rdat1,
    output logic [31:0]      rdat2,
    output logic             fwd_valid,
    output logic [4:0]       fwd_sel,
    output logic [31:0]      fwd_data,
    output logic             halt,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned NREGS = 32;

    logic [31:0]      r_regs [NREGS];
    logic             r_halt;
    logic [CNT_W-1:0] r_retired;

    logic             w_is_halt;
    logic [4:0]       w_wsel;
    logic [31:0]      w_wdat;
    logic             w_we;

    assign w_is_halt = (instr_WB[31:26] == HALT_OP);

    // Destination select; RegDst 11 leaves wsel at 0, which also blocks the write
    always_comb begin
        w_wsel = 5'd0;
        case (RegDst_WB)
            2'b00:   w_wsel = instr_WB[20:16];
            2'b01:   w_wsel = instr_WB[15:11];
            2'b10:   w_wsel = LINK_REG;
            default: w_wsel = 5'd0;
        endcase
    end

    // Write data: link address for JAL, else load data or ALU result
    always_comb begin
        w_wdat = Output_Port_WB;
        if (RegDst_WB == 2'b10) begin
            w_wdat = imemaddr_WB + 32'd4;
        end else if (memtoReg_WB) begin
            w_wdat = dmemload_WB;
        end
    end

    assign w_we = valid_WB & RegWr_WB & (RegDst_WB != 2'b11) & (w_wsel != 5'd0)
                & ~r_halt & ~w_is_halt;

    // Read ports: R0 hardwired, then write-before-read bypass, then storage
    always_comb begin
        rdat1 = r_regs[rsel1];
        if (rsel1 == 5'd0) begin
            rdat1 = 32'd0;
        end else if (w_we && (rsel1 == w_wsel)) begin
            rdat1 = w_wdat;
        end
    end

    always_comb begin
        rdat2 = r_regs[rsel2];
        if (rsel2 == 5'd0) begin
            rdat2 = 32'd0;
        end else if (w_we && (rsel2 == w_wsel)) begin
            rdat2 = w_wdat;
        end
    end

    assign fwd_valid = w_we;
    assign fwd_sel   = w_we ? w_wsel : 5'd0;
    assign fwd_data  = w_we ? w_wdat : 32'd0;

    assign halt    = r_halt;
    assign retired = r_retired;

    // Register file, halt latch and retire counter; reset wins over everything
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                r_regs[i] <= 32'd0;
            end
            r_halt    <= 1'b0;
            r_retired <= '0;
        end else begin
            if (w_we) begin
                r_regs[w_wsel] <= w_wdat;
            end
            if (valid_WB && !r_halt) begin
                r_retired <= r_retired + CNT_W'(1);
                if (w_is_halt) begin
                    r_halt <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage.
module tb_writeback_stage;

    logic        CLK;
    logic        RST;
    logic        valid_WB;
    logic        RegWr_WB;
    logic        memtoReg_WB;
    logic [1:0]  RegDst_WB;
    logic [31:0] Output_Port_WB;
    logic [31:0] dmemload_WB;
    logic [31:0] imemaddr_WB;
    logic [31:0] instr_WB;
    logic [4:0]  rsel1;
    logic [4:0]  rsel2;
    logic [31:0] rdat1;
    logic [31:0] rdat2;
    logic        fwd_valid;
    logic [4:0]  fwd_sel;
    logic [31:0] fwd_data;
    logic        halt;
    logic [31:0] retired;

    int n_checks = 0;
    int n_errors = 0;

    writeback_stage dut (
        .CLK            (CLK),
        .RST            (RST),
        .valid_WB       (valid_WB),
        .RegWr_WB       (RegWr_WB),
        .memtoReg_WB    (memtoReg_WB),
        .RegDst_WB      (RegDst_WB),
        .Output_Port_WB (Output_Port_WB),
        .dmemload_WB    (dmemload_WB),
        .imemaddr_WB    (imemaddr_WB),
        .instr_WB       (instr_WB),
        .rsel1          (rsel1),
        .rsel2          (rsel2),
        .rdat1          (rdat1),
        .rdat2          (rdat2),
        .fwd_valid      (fwd_valid),
        .fwd_sel        (fwd_sel),
        .fwd_data       (fwd_data),
        .halt           (halt),
        .retired        (retired)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rt,
                                       input logic [4:0] rd);
        return {op, 5'd0, rt, rd, 11'd0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one WB-side vector at the falling edge, then let comb settle
    task automatic drive(input logic v, input logic rw, input logic mtr, input logic [1:0] dst,
                         input logic [31:0] alu, input logic [31:0] dml, input logic [31:0] pc,
                         input logic [31:0] ins, input logic [4:0] s1, input logic [4:0] s2);
        @(negedge CLK);
        valid_WB = v; RegWr_WB = rw; memtoReg_WB = mtr; RegDst_WB = dst;
        Output_Port_WB = alu; dmemload_WB = dml; imemaddr_WB = pc; instr_WB = ins;
        rsel1 = s1; rsel2 = s2;
        #1;
    endtask

    task automatic edge_step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1;
        valid_WB = 1'b0; RegWr_WB = 1'b0; memtoReg_WB = 1'b0; RegDst_WB = 2'b00;
        Output_Port_WB = '0; dmemload_WB = '0; imemaddr_WB = '0; instr_WB = '0;
        rsel1 = 5'd5; rsel2 = 5'd31;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("reset_rdat1", rdat1, 32'd0);
        chk("reset_rdat2", rdat2, 32'd0);
        chk("reset_halt", 32'(halt), 32'd0);
        chk("reset_retired", retired, 32'd0);

        // ALU write to rd=5 with same-cycle bypass
        drive(1, 1, 0, 2'b01, 32'hDEADBEEF, 32'h0, 32'h40, mk(6'd0, 5'd2, 5'd5), 5'd5, 5'd0);
        chk("byp_rdat1", rdat1, 32'hDEADBEEF);
        chk("byp_rdat2_r0", rdat2, 32'd0);
        chk("byp_fwd_valid", 32'(fwd_valid), 32'd1);
        chk("byp_fwd_sel", 32'(fwd_sel), 32'd5);
        chk("byp_fwd_data", fwd_data, 32'hDEADBEEF);
        edge_step();
        chk("retired_1", retired, 32'd1);
        drive(0, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd5);
        chk("stored_r5", rdat1, 32'hDEADBEEF);
        chk("bubble_fwd_valid", 32'(fwd_valid), 32'd0);
        edge_step();

        // Load to rt=7, other port reads stored R5
        drive(1, 1, 1, 2'b00, 32'h11111111, 32'hCAFE0001, 32'h44, mk(6'd0, 5'd7, 5'd9), 5'd5, 5'd7);
        chk("load_rdat1_r5", rdat1, 32'hDEADBEEF);
        chk("load_rdat2_byp", rdat2, 32'hCAFE0001);
        chk("load_fwd_sel", 32'(fwd_sel), 32'd7);
        edge_step();
        chk("retired_2", retired, 32'd2);

        // JAL: link = PC + 4 into R31
        drive(1, 1, 0, 2'b10, 32'h22222222, 32'h33333333, 32'h00000100, mk(6'd3, 5'd4, 5'd3), 5'd31, 5'd7);
        chk("jal_rdat1", rdat1, 32'h00000104);
        chk("jal_fwd_sel", 32'(fwd_sel), 32'd31);
        chk("stored_r7", rdat2, 32'hCAFE0001);
        edge_step();
        // JAL at the top of the address space wraps to 0
        drive(1, 1, 0, 2'b10, 32'h22222222, 32'h0, 32'hFFFFFFFC, mk(6'd3, 5'd0, 5'd0), 5'd31, 5'd31);
        chk("jal_wrap_byp", rdat1, 32'h00000000);
        chk("jal_wrap_fwd_valid", 32'(fwd_valid), 32'd1);
        edge_step();
        chk("retired_4", retired, 32'd4);
        drive(0, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 5'd31, 5'd3);
        chk("jal_wrap_stored", rdat1, 32'h00000000);
        chk("r3_untouched", rdat2, 32'h00000000);
        edge_step();

        // Both ports bypass the same register
        drive(1, 1, 0, 2'b01, 32'h000055AA, 32'h0, 32'h50, mk(6'd0, 5'd1, 5'd10), 5'd10, 5'd10);
        chk("dual_byp1", rdat1, 32'h000055AA);
        chk("dual_byp2", rdat2, 32'h000055AA);
        edge_step();

        // Load to rt=0: dropped, no forward
        drive(1, 1, 1, 2'b00, 32'h0, 32'h00001234, 32'h54, mk(6'd35, 5'd0, 5'd6), 5'd0, 5'd6);
        chk("r0_fwd_valid", 32'(fwd_valid), 32'd0);
        chk("r0_rdat1", rdat1, 32'd0);
        edge_step();
        chk("retired_6", retired, 32'd6);

        // RegDst 11 never writes, even with rd=6
        drive(1, 1, 0, 2'b11, 32'h00000066, 32'h0, 32'h58, mk(6'd0, 5'd6, 5'd6), 5'd6, 5'd0);
        chk("nodst_fwd_valid", 32'(fwd_valid), 32'd0);
        chk("nodst_rdat1", rdat1, 32'd0);
        edge_step();
        chk("retired_7", retired, 32'd7);

        // Bubble with RegWr set: no write, no retire
        drive(0, 1, 0, 2'b01, 32'h00000099, 32'h0, 32'h5C, mk(6'd0, 5'd0, 5'd6), 5'd6, 5'd0);
        chk("bubble_rw_fwd", 32'(fwd_valid), 32'd0);
        edge_step();
        chk("bubble_retired", retired, 32'd7);
        chk("bubble_r6", rdat1, 32'd0);

        // R3 = 7
        drive(1, 1, 0, 2'b01, 32'h00000007, 32'h0, 32'h60, mk(6'd0, 5'd0, 5'd3), 5'd3, 5'd0);
        edge_step();
        chk("retired_8", retired, 32'd8);

        // HALT with RegWr targeting R3: no write, counts as retired
        drive(1, 1, 0, 2'b01, 32'h00000BAD, 32'h0, 32'h64, mk(6'b111111, 5'd0, 5'd3), 5'd3, 5'd0);
        chk("halt_fwd_valid", 32'(fwd_valid), 32'd0);
        chk("halt_no_byp", rdat1, 32'h00000007);
        chk("halt_pre", 32'(halt), 32'd0);
        edge_step();
        chk("halt_set", 32'(halt), 32'd1);
        chk("retired_9", retired, 32'd9);

        // Writes and retirement frozen after halt
        drive(1, 1, 0, 2'b01, 32'h00000077, 32'h0, 32'h68, mk(6'd0, 5'd0, 5'd3), 5'd3, 5'd0);
        chk("post_halt_fwd", 32'(fwd_valid), 32'd0);
        chk("post_halt_rdat", rdat1, 32'h00000007);
        edge_step();
        chk("post_halt_retired", retired, 32'd9);
        chk("post_halt_r3", rdat1, 32'h00000007);
        chk("halt_sticky", 32'(halt), 32'd1);

        // RST clears halt, counter and registers
        @(negedge CLK);
        RST = 1'b1;
        valid_WB = 1'b0;
        edge_step();
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("rst_halt", 32'(halt), 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_r3", rdat1, 32'd0);

        // R9 = 0x11, then RST together with a write to R9
        drive(1, 1, 0, 2'b01, 32'h00000011, 32'h0, 32'h70, mk(6'd0, 5'd0, 5'd9), 5'd9, 5'd0);
        edge_step();
        chk("r9_written_retired", retired, 32'd1);
        drive(1, 1, 0, 2'b01, 32'h00000099, 32'h0, 32'h74, mk(6'd0, 5'd0, 5'd9), 5'd9, 5'd9);
        RST = 1'b1;
        edge_step();
        drive(0, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 5'd9, 5'd0);
        RST = 1'b0;
        #1;
        chk("rst_prio_r9", rdat1, 32'd0);
        chk("rst_prio_retired", retired, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
